// File: rtl/fine_interp_tdc.sv
// Time-to-digital converter: coarse cycle counter plus Johnson-coded phase taps.
// Measures pulse width or period in units of T_clk/(2*NPHASE).
module fine_interp_tdc #(
    parameter int NPHASE = 4,
    parameter int CNT_W  = 24,
    localparam int FW    = $clog2(2 * NPHASE),
    localparam int RW    = CNT_W + FW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic [NPHASE-1:0] tap_code,
    input  logic              rise_stb,
    input  logic              fall_stb,
    output logic [RW-1:0]     res_data,
    output logic [2:0]        res_flags,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        drop_cnt,
    output logic              busy
);

    typedef enum logic {IDLE, MEAS} state_t;

    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t            state;
    logic [CNT_W-1:0]  coarse;
    logic [FW-1:0]     fine_start;
    logic              bub_start;
    logic              mode_q;

    logic [FW-1:0]     tap_fine;
    logic              tap_bub;
    logic              stop;
    logic              done_ok;
    logic              done_ovf;
    logic              new_res;
    logic [RW-1:0]     span;
    logic [RW-1:0]     nxt_data;
    logic [2:0]        nxt_flags;

    // Returns {bubble, fine}; any non-Johnson pattern decodes as a bubble with fine=0.
    function automatic logic [FW:0] decode(input logic [NPHASE-1:0] code);
        logic [NPHASE-1:0] ones;
        logic [FW:0]       r;
        ones = '1;
        r    = {1'b1, {FW{1'b0}}};
        for (int j = 1; j <= NPHASE; j++)
            if (code == ~(ones >> j))
                r = {1'b0, FW'(2 * NPHASE - j)};
        for (int j = 0; j < NPHASE; j++)
            if (code == (ones >> (NPHASE - j)))
                r = {1'b0, FW'(j)};
        return r;
    endfunction

    always_comb begin
        {tap_bub, tap_fine} = decode(tap_code);
        stop     = mode_q ? rise_stb : fall_stb;
        done_ok  = (state == MEAS) && enable && stop;
        done_ovf = (state == MEAS) && enable && !stop && (coarse == CMAX);
        new_res  = done_ok || done_ovf;
        // Stop lands D = coarse+1 cycles after the start strobe.
        span = (RW'(coarse) + RW'(1)) * RW'(2 * NPHASE)
             + RW'(fine_start) - RW'(tap_fine);
        if (done_ovf) begin
            nxt_data  = '1;
            nxt_flags = {1'b1, 1'b0, bub_start};
        end else begin
            nxt_data  = span;
            nxt_flags = {1'b0, tap_bub, bub_start};
        end
    end

    assign busy = (state == MEAS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            coarse     <= '0;
            fine_start <= '0;
            bub_start  <= 1'b0;
            mode_q     <= 1'b0;
            res_data   <= '0;
            res_flags  <= '0;
            res_valid  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && rise_stb) begin
                        fine_start <= tap_fine;
                        bub_start  <= tap_bub;
                        mode_q     <= mode;
                        coarse     <= '0;
                        state      <= MEAS;
                    end
                end
                MEAS: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (stop) begin
                        if (mode_q) begin
                            fine_start <= tap_fine;
                            bub_start  <= tap_bub;
                            coarse     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (coarse == CMAX) begin
                        state <= IDLE;
                    end else begin
                        coarse <= coarse + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (new_res && (!res_valid || res_ready)) begin
                res_data  <= nxt_data;
                res_flags <= nxt_flags;
                res_valid <= 1'b1;
            end else begin
                if (res_valid && res_ready)
                    res_valid <= 1'b0;
                if (new_res && drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/fine_interp_tdc.md
FINE_INTERP_TDC -- requirements
Module: fine_interp_tdc

Interface
REQ-001 Parameters:
  - NPHASE, 4, number of phase taps (>=2); fine resolution is T_clk/(2*NPHASE).
  - CNT_W, 24, coarse counter width.
  - FW, clog2(2*NPHASE), derived, fine field width.
REQ-002 Ports:
  - clk  in  1  single clock; all logic is on its rising edge.
  - reset  in  1  synchronous, active-high.
  - enable  in  1  0 aborts any measurement and holds FSM in IDLE.
  - mode  in  1  0 = pulse width (rise->fall), 1 = period (rise->rise).
  - tap_code  in  NPHASE  phase-tap snapshot captured at the gate edge; valid in the strobe cycle.
  - rise_stb  in  1  one-cycle strobe: gate rising edge captured.
  - fall_stb  in  1  one-cycle strobe: gate falling edge captured.
  - res_data  out  CNT_W+FW  interval in fine units.
  - res_flags  out  3  {overflow, bubble_fall/stop, bubble_rise/start}.
  - res_valid  out  1  result available.
  - res_ready  in  1  consumer accepts result.
  - drop_cnt  out  8  saturating count of results lost to backpressure.
  - busy  out  1  FSM in MEAS.

Function
REQ-003 Decode tap_code (Johnson code) as follows:
  - MSB=1 with ones in the top j bits (j=1..NPHASE) -> fine = 2*NPHASE-j.
  - MSB=0 with ones in the bottom j bits (j=0..NPHASE-1) -> fine = j.
  - With NPHASE=4: 1000->7, 1100->6, 1110->5, 1111->4, 0111->3, 0011->2, 0001->1, 0000->0.
REQ-004 Any other code is a bubble: fine=0 and the matching bubble flag is set for that result.
REQ-005 The FSM has two states, IDLE and MEAS; reset and enable=0 force IDLE.
REQ-006 IDLE: on rise_stb with enable=1:
  - latch fine_start from tap_code;
  - latch mode into mode_q;
  - clear coarse to 0;
  - go to MEAS.
  fall_stb in IDLE is ignored.
REQ-007 MEAS: coarse increments by 1 every cycle without a stop event, saturating at 2^CNT_W-1. mode and tap_code are ignored except in strobe cycles.
REQ-008 Stop event depends on mode_q:
  - mode_q=0: the stop is fall_stb; rise_stb is ignored, and fall wins when both strobes occur together.
  - mode_q=1: the stop is rise_stb; fall_stb is ignored.
REQ-009 On a stop in cycle s+D, where the start strobe was in cycle s:
  - result = D*2*NPHASE + fine_start - fine_stop (unsigned, CNT_W+FW bits; D>=1 guarantees result >= 1);
  - bubble flags are taken from the start and stop decodes.
REQ-010 After a stop with mode_q=0, go to IDLE.
REQ-011 After a stop with mode_q=1, remain in MEAS and restart: the stop edge becomes the new start (fine_start = fine_stop, coarse = 0), giving back-to-back periods with no dead cycle.
REQ-012 Overflow: in MEAS, if coarse = 2^CNT_W-1 and no stop occurs:
  - the measurement ends;
  - result = all-ones with overflow=1;
  - FSM goes to IDLE in both modes.
REQ-013 Output register: a completed result is written to res_data/res_flags and res_valid=1 at the same clock edge that samples the stop strobe (latency 1 edge).
REQ-014 Handshake: a transfer occurs on any edge with res_valid=1 and res_ready=1; res_valid then clears unless a new result is loaded on that same edge.
REQ-015 Backpressure:
  - If a result completes while res_valid=1 and res_ready=0, the new result is discarded and drop_cnt increments, saturating at 255.
  - The held result and its flags are unchanged.
REQ-016 If a result completes on the same edge as a transfer, the new result is loaded and res_valid stays 1.
REQ-017 enable=0 during MEAS:
  - the measurement is aborted with no result and no drop count;
  - the output register and res_valid are unaffected.
REQ-018 busy=1 exactly when the FSM is in MEAS.

Reset
REQ-019 When reset=1 at a clock edge, the following values are set:
  - FSM=IDLE;
  - res_valid=0, res_data=0, res_flags=0;
  - drop_cnt=0, busy=0, coarse=0;
  - fine_start=0, mode_q=0.
REQ-020 Reset overrides every other input, including mid-measurement and a pending res_valid; the first start is accepted on the first edge after reset deasserts.

Verification (NPHASE=4, CNT_W=24 unless stated)
REQ-021 Width mode: rise_stb with 1100, fall_stb 5 cycles later with 0011 -> res_data=44, flags=000, res_valid at the fall edge.
REQ-022 Period mode: rise_stb at cycles 0, 3 and 7 with taps 1000, 0001 and 1111 -> results 30 then 29; busy stays 1 throughout.
REQ-023 Bubble: rise with 1010, fall 2 cycles later with 0000 -> res_data=16, flags=001.
REQ-024 Overflow (CNT_W=4): rise with no fall -> after coarse reaches 15, res_data all-ones (7 bits), flags=100, busy=0.
REQ-025 Backpressure: res_ready=0 with two width-mode results -> first result held and drop_cnt=1; res_ready=1 on the same edge as a third completion -> third result loaded and res_valid remains 1.
REQ-026 Reset or enable=0 asserted mid-MEAS -> busy=0 with no result; with reset, all outputs are 0 on the next edge.
